encoder_8to3_queued: RTL
========================

# encoder_8to3_queued

Sequential 8-to-3 event encoder, the inverse of the team's 3-to-8 select decoder. Eight single-bit request lines each raise a sticky pending flag. The block emits the 3-bit index of one pending line at a time over a valid/ready handshake and clears each flag as its code is accepted. It sits between raw event sources (interrupt lines, status strobes) and any consumer that drives a 3-to-8 decoder from the returned code.

## Interface
- `ROUND_ROBIN`, default 0: 0 = fixed priority (lowest index wins); 1 = rotating priority starting after the last served index.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 8: request pulses or levels; bit i high in a cycle sets pending[i].
- `code` out 3: index of the presented request; valid only while `valid`=1.
- `valid` out 1: code is presented; held until accepted.
- `ready` in 1: consumer accepts `code` when `valid`&&`ready` at a rising edge.
- `pending` out 8: registered pending flags, for status/debug.
- `overflow` out 1: one-cycle pulse when a request hits an already-pending, not-being-served bit.
- `idle` out 1: high when `pending`==0 and `valid`==0.

## Operation
- Reset values: `code`=0, `valid`=0, `pending`=0, `overflow`=0, `idle`=1, FSM=IDLE, RR pointer=7 (first search starts at index 0).
- served[7:0] = one-hot(`code`) when `valid`&&`ready`, else 0.
- cand = (pending & ~served) | req. pending_next = cand.
- overflow_next = |(req & pending & ~served). A request on the bit served in the same cycle re-arms that bit and does not flag overflow.
- Winner select on cand:
  - Fixed priority: lowest set index.
  - Round-robin: lowest set index strictly above the pointer, wrapping 7→0. The pointer updates to `code` on each handshake.
- FSM states:
  - IDLE (`valid`=0): if cand≠0, register `code`=winner and `valid`=1, then go to PRESENT. Otherwise stay.
  - PRESENT (`valid`=1): without a handshake, `code` and `valid` hold, even if a higher-priority request arrives (no preemption). On a handshake, if cand≠0, load the next winner at the same edge and stay in PRESENT (back-to-back, no bubble). If cand=0, go to IDLE with `valid`=0.
- The winner is never the bit just served unless req re-asserted it that cycle. In fixed mode it can then win again.
- `ready` is ignored while `valid`=0.
- `rst` mid-operation: all pending requests and any presented code are discarded immediately. No handshake completes.

## Timing
- Latency: req bit set at edge k, with the block IDLE and no other pending → `valid`=1 and `code` = that index after edge k (visible in cycle k+1).
- Throughput: one code per cycle while `ready`=1 and requests remain.
- All outputs are registered. There are no combinational paths from `req`/`ready` to outputs.
- `pending` reflects the state after the edge. The presented bit stays set in `pending` until its handshake edge.
- Simultaneous `req` on all 8 bits with `ready` tied high produces 8 consecutive codes.

## Structure
- Shared package/header `vlsi_lab_pkg`:
  - width constants N_REQ=8 and CODE_W=3.
  - FSM state encodings ST_IDLE and ST_PRESENT.
- One sub-module, `prio_pick8`:
  - Combinational; inputs are the 8-bit vector and the 3-bit start pointer.
  - Outputs are the 3-bit index and an any-set flag.
  - Fixed mode drives the pointer as 7.
- Top level holds the pending register, FSM, RR pointer and output registers.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `valid`=1 and `pending`=8'h5A → `valid`=0, `pending`=0, `idle`=1 immediately; no handshake completes.
- Fixed priority drain: `req`=8'b1010_0100 for one cycle, `ready`=1 → `code` 2, 5, 7 on three consecutive cycles, then `valid`=0 and `idle`=1.
- Backpressure: `req`=8'h01, `ready`=0 for 5 cycles, with `req`=8'h80 pulsed in cycle 2 → `code`=0 held all 5 cycles. After `ready`=1: 0 then 7.
- Overflow: pending[3]=1 and not presented, `req`[3] pulsed → `overflow`=1 for exactly one cycle, only one code 3 emitted. `req`[3] pulsed in the handshake cycle of code 3 → no overflow, code 3 emitted again.
- Round-robin (`ROUND_ROBIN`=1): `req`=8'hFF held high, `ready`=1 → codes 0,1,2,…,7,0,1 with no repeats before wrap. Fixed mode with the same stimulus → code 0 every cycle.
- Idle/latency: single `req`=8'h10 from idle → `valid`=1 with `code`=4 one cycle after the edge sampling `req`.

Source files
------------

// File: rtl/vlsi_lab_pkg.sv
// Shared definitions for the queued 8-to-3 event encoder.
//   N_REQ / CODE_W : request-vector and code widths
//   state_t        : presentation FSM encoding (ST_IDLE, ST_PRESENT)
//   onehot()       : expands a code into its one-hot request position
package vlsi_lab_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] c);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational rotating priority picker over an 8-bit vector.
//   vec : candidate bits
//   ptr : search starts at ptr+1 and wraps 7->0; ptr=7 gives fixed lowest-index priority
//   idx : index of the first set bit found
//   any : high when any bit of vec is set
module prio_pick8
  import vlsi_lab_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  input  logic [CODE_W-1:0] ptr,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [CODE_W-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    // i = N_REQ wraps back onto ptr itself, so it is searched last
    for (int i = 1; i <= int'(N_REQ); i++) begin
      pos = ptr + CODE_W'(i);
      if (!any && vec[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/encoder_8to3_queued.sv
// Sequential 8-to-3 event encoder. Each request bit sets a sticky pending flag; pending
// indices are presented one at a time over a valid/ready handshake and cleared on accept.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request bits, each high cycle sets the matching pending flag
//   code     : presented index (meaningful while valid)
//   valid    : code presented, held until accepted
//   ready    : consumer accepts code when valid && ready at a rising edge
//   pending  : registered pending flags
//   overflow : one-cycle pulse when a request hits a pending, not-being-served bit
//   idle     : high when nothing is pending or presented
module encoder_8to3_queued
  import vlsi_lab_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [N_REQ-1:0]  pending,
  output logic              overflow,
  output logic              idle
);

  state_t            state_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [N_REQ-1:0]  pending_q;
  logic              overflow_q;
  logic              idle_q;
  logic [CODE_W-1:0] rr_ptr_q;

  logic              hs;
  logic [N_REQ-1:0]  served;
  logic [N_REQ-1:0]  cand;
  logic              ovf_d;
  logic [CODE_W-1:0] pick_ptr;
  logic [CODE_W-1:0] pick_idx;
  logic              pick_any;

  always_comb begin
    hs     = valid_q && ready;
    served = hs ? onehot(code_q) : '0;
    cand   = (pending_q & ~served) | req;
    // a request on the bit being served re-arms it rather than overflowing
    ovf_d  = |(req & pending_q & ~served);
    // on a handshake the pointer moves to code_q at this edge, so search from there now
    if (ROUND_ROBIN) begin
      pick_ptr = hs ? code_q : rr_ptr_q;
    end else begin
      pick_ptr = CODE_W'(N_REQ - 1);
    end
  end

  prio_pick8 u_pick (
    .vec (cand),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      valid_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      idle_q     <= 1'b1;
      rr_ptr_q   <= CODE_W'(N_REQ - 1);
    end else begin
      pending_q  <= cand;
      overflow_q <= ovf_d;
      // while presenting without a handshake cand still holds the presented bit
      idle_q     <= ~|cand;
      if (hs) begin
        rr_ptr_q <= code_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            code_q  <= pick_idx;
            valid_q <= 1'b1;
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // no preemption: code changes only on a handshake
          if (ready) begin
            if (pick_any) begin
              code_q <= pick_idx;
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign idle     = idle_q;

endmodule
